mul_seq_ctrl: RTL

- FSM controller that sequences the shift-add multiplier datapath: multiplicand register, product/shift register, ripple-carry adder.
- Accepts a start request over a valid/ready handshake, issues per-cycle load/add/shift strobes for WIDTH iterations, and pulses done when the product is valid.
- Replaces the ad-hoc pulse-generator/counter pairing with one verifiable sequencer.

---
 rtl/mul_seq_pkg.sv | 15 +
 rtl/mul_iter_cnt.sv | 36 +++
 rtl/mul_seq_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/mul_seq_pkg.sv
// Shared types and defaults for the shift-add multiplier sequencer.
package mul_seq_pkg;

    localparam int unsigned MUL_WIDTH_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_TEST  = 3'd2,
        ST_ADD   = 3'd3,
        ST_SHIFT = 3'd4,
        ST_DONE  = 3'd5
    } mul_state_e;

endpackage

// File: rtl/mul_iter_cnt.sv
// Iteration counter for the multiplier sequencer; tc flags the last iteration.
module mul_iter_cnt #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] cnt_o,
    output logic          tc_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/mul_seq_ctrl.sv
// Shift-add multiplier sequencer: handshake accept, per-iteration strobes, done pulse.
// Optional sticky protocol error output enabled by MUL_SEQ_START_ERR_EN.
module mul_seq_ctrl
    import mul_seq_pkg::*;
#(
    parameter  int unsigned WIDTH = MUL_WIDTH_DEF,
    localparam int unsigned CW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_valid,
    output logic          start_ready,
    input  logic          p_lsb,
    output logic          a_ld,
    output logic          p_init,
    output logic          p_add,
    output logic          p_shift,
    output logic          busy,
    output logic          done,
`ifdef MUL_SEQ_START_ERR_EN
    output logic          err,
`endif
    output logic [CW-1:0] iter
);

    mul_state_e state_q, state_d;
    logic       cnt_clr, cnt_en, cnt_tc;

    mul_iter_cnt #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_iter_cnt (
        .clk   (clk),
        .reset (reset),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .cnt_o (iter),
        .tc_o  (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        start_ready = 1'b0;
        a_ld        = 1'b0;
        p_init      = 1'b0;
        p_add       = 1'b0;
        p_shift     = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                start_ready = 1'b1;
                if (start_valid) state_d = ST_INIT;
            end
            ST_INIT: begin
                a_ld    = 1'b1;
                p_init  = 1'b1;
                busy    = 1'b1;
                cnt_clr = 1'b1;
                state_d = ST_TEST;
            end
            ST_TEST: begin
                busy    = 1'b1;
                state_d = p_lsb ? ST_ADD : ST_SHIFT;
            end
            ST_ADD: begin
                p_add   = 1'b1;
                busy    = 1'b1;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                p_shift = 1'b1;
                busy    = 1'b1;
                // iter freezes on the last pass so it still reads WIDTH-1 in DONE
                cnt_en  = !cnt_tc;
                state_d = cnt_tc ? ST_DONE : ST_TEST;
            end
            ST_DONE: begin
                done    = 1'b1;
                busy    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef MUL_SEQ_START_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (start_valid && (state_q != ST_IDLE) && (state_q != ST_DONE)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule
